gpio_switch_scanner: RTL and testbench
======================================

# gpio_switch_scanner

Input-side companion to the GPIO expansion board output driver: scans the board's 32 DIP switches as four multiplexed 8-bit banks, debounces the assembled 32-bit word across successive full scans, and presents a stable `dip_sw` word with valid and change strobes. It sits between the GPIO1 connector pins and board-level test or CPU logic that consumes switch settings.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 16: clock cycles a bank select is held before its data is sampled; legal range 1..255, and ≥3 when `GPIO_SW_SYNC_EN` is defined.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full-frame samples required before `dip_sw` updates; legal range 1..15.

Ports:
- `clock`: input, 1 bit. Single clock; all logic is on the rising edge.
- `reset_n`: input, 1 bit. Asynchronous, active-low reset.
- `scan_en`: input, 1 bit. Enables continuous scanning.
- `bank_sel`: output, 4 bits. Active-low, one-hot bank select driven to the board; `4'hF` means no bank is selected.
- `bank_data`: input, 8 bits. Switch data for the selected bank. A line is low when its switch is closed.
- `dip_sw`: output, 32 bits. Debounced switch word; a bit is 1 when its switch is closed.
- `dip_valid`: output, 1 bit. Goes high after the first debounced frame and stays high until reset.
- `dip_change`: output, 1 bit. One-cycle pulse when `dip_sw` changes value.
- `frame_done`: output, 1 bit. One-cycle pulse at the end of every full scan.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, COMPARE. The bank index `b` is 2 bits.
- **IDLE**
  - `bank_sel` is `4'hF`.
  - If `scan_en` is 1, set `b = 0` and go to DRIVE.
- **DRIVE**
  - `bank_sel = ~(4'b0001 << b)`.
  - The settle counter counts 1..`SETTLE_CYCLES`, then the FSM goes to SAMPLE.
- **SAMPLE**
  - `bank_sel` still selects bank `b`.
  - Capture `raw[8b+7:8b] = ~bank_data`.
  - If `b == 3`, go to COMPARE. Otherwise increment `b` and go to DRIVE.
- **COMPARE**
  - `bank_sel` is `4'hF`.
  - Stability count: if `raw == prev_raw`, increment the 4-bit count, saturating at `DEBOUNCE_SCANS`. Otherwise set the count to 1.
  - Then set `prev_raw = raw`.
  - Update rule: if the updated count equals `DEBOUNCE_SCANS` and either `raw != dip_sw` or `dip_valid == 0`, then:
    - load `dip_sw = raw`,
    - set `dip_valid = 1`,
    - pulse `dip_change`, but only when the new value differs from the old `dip_sw`.
  - Pulse `frame_done`.
  - Next state: DRIVE with `b = 0` if `scan_en` is 1; otherwise IDLE.
- **`scan_en` deasserted mid-frame:** the current frame completes, including COMPARE, then the FSM enters IDLE. A partial frame is never discarded.
- **Bank mapping:** bank `i` covers `dip_sw[8i+7:8i]`.
- **`DEBOUNCE_SCANS == 1`:** every frame updates `dip_sw`.
- **Reset (asynchronous, taking effect immediately, also mid-frame):**
  - State goes to IDLE; `bank_sel` goes to `4'hF`.
  - `dip_sw`, `raw`, `prev_raw`, and the stability count clear to 0.
  - `dip_valid`, `dip_change`, and `frame_done` go to 0.

## Timing
- **Per bank:** `SETTLE_CYCLES` DRIVE cycles plus 1 SAMPLE cycle.
- **Frame period:** 4·(`SETTLE_CYCLES`+1) + 1 cycles.
  - With defaults this is 69 cycles.
  - Back-to-back frames have no IDLE gap while `scan_en` stays high.
- **Timing of COMPARE results:** `dip_sw`, `dip_valid`, `dip_change`, and `frame_done` update on the clock edge that leaves COMPARE. They are registered outputs.
- **Response to a clean, stable new switch pattern:**
  - Minimum: `dip_sw` reflects it `DEBOUNCE_SCANS` frames after the first frame that fully sees it.
  - Maximum: one additional frame if the change lands mid-frame.
- **`scan_en` rising in IDLE:** bank 0 is selected on the next edge.

## Configuration
- **Macro:** `GPIO_SW_SYNC_EN`.
- **Defined:**
  - `bank_data` passes through a two-flop synchronizer, and SAMPLE captures the synchronized value.
  - The effective pin-to-capture window is shortened by 2 cycles.
  - `SETTLE_CYCLES` must be ≥3.
  - Synchronizer flops reset to `8'hFF`.
- **Undefined:** SAMPLE captures `bank_data` directly. The pins must be externally synchronous or tolerate metastability.

## Test plan
- **Bank sequence:** `SETTLE_CYCLES`=4, `scan_en`=1 → `bank_sel` steps 1110, 1101, 1011, 0111, each held 5 cycles; then 1 cycle of 1111 with a `frame_done` pulse; frame period is 21 cycles.
- **Static pattern:** `DEBOUNCE_SCANS`=3; `bank_data` per bank b0=`~8'hF0`, b1=`~8'h0F`, b2=`~8'hC3`, b3=`~8'hA5` → at the end of frame 3, `dip_sw=32'hA5C3_0FF0` and `dip_valid` rises. `dip_change` pulses exactly once; no further pulses while the input is constant.
- **Bounce rejection:** toggle bank 1 bit 0 every frame for 10 frames → `dip_sw` holds its prior value and `dip_change` never pulses. Hold the new value for 3 frames → `dip_sw[8]` updates.
- **Scan stop:** drop `scan_en` during bank 2 DRIVE → banks 2 and 3 still scan, COMPARE and `frame_done` occur, then `bank_sel` stays at `4'hF` and no further frames start.
- **Reset mid-frame:** assert `reset_n`=0 during bank 1 SAMPLE → immediately `bank_sel=4'hF`, `dip_sw=0`, `dip_valid=0`. After release, debounce restarts from count 0.
- **`GPIO_SW_SYNC_EN` build:** change `bank_data` 1 cycle before SAMPLE → the old value is captured. Change it 3 cycles before SAMPLE → the new value is captured.

Source files
------------

// File: rtl/gpio_switch_scanner.sv
// Scans 32 DIP switches as four active-low multiplexed 8-bit banks and debounces whole frames.
// Define GPIO_SW_SYNC_EN to pass bank_data through a two-flop synchronizer before sampling.
module gpio_switch_scanner #(
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        scan_en,
   output logic [3:0]  bank_sel,
   input  logic [7:0]  bank_data,
   output logic [31:0] dip_sw,
   output logic        dip_valid,
   output logic        dip_change,
   output logic        frame_done
);

   typedef enum logic [1:0] {StIdle, StDrive, StSample, StCompare} state_e;

   localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
   localparam logic [3:0] DebTarget  = 4'(DEBOUNCE_SCANS);

   state_e      state_q, state_d;
   logic [1:0]  bank_q, bank_d;
   logic [7:0]  settle_q, settle_d;
   logic [31:0] raw_q, raw_d;
   logic [31:0] prev_q, prev_d;
   logic [31:0] dip_q, dip_d;
   logic [3:0]  stab_q, stab_d;
   logic        valid_q, valid_d;
   logic        change_q, change_d;
   logic        done_q, done_d;
   logic [7:0]  data_s;

`ifdef GPIO_SW_SYNC_EN
   logic [7:0] sync1_q, sync2_q;

   // Idle-high reset value matches an unselected bank with all switches open.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 8'hFF;
         sync2_q <= 8'hFF;
      end else begin
         sync1_q <= bank_data;
         sync2_q <= sync1_q;
      end
   end

   assign data_s = sync2_q;
`else
   assign data_s = bank_data;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         bank_q   <= 2'd0;
         settle_q <= 8'd0;
         raw_q    <= 32'd0;
         prev_q   <= 32'd0;
         dip_q    <= 32'd0;
         stab_q   <= 4'd0;
         valid_q  <= 1'b0;
         change_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bank_q   <= bank_d;
         settle_q <= settle_d;
         raw_q    <= raw_d;
         prev_q   <= prev_d;
         dip_q    <= dip_d;
         stab_q   <= stab_d;
         valid_q  <= valid_d;
         change_q <= change_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      bank_d   = bank_q;
      settle_d = settle_q;
      raw_d    = raw_q;
      prev_d   = prev_q;
      dip_d    = dip_q;
      stab_d   = stab_q;
      valid_d  = valid_q;
      change_d = 1'b0;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (scan_en) begin
               bank_d   = 2'd0;
               settle_d = 8'd0;
               state_d  = StDrive;
            end
         end
         StDrive: begin
            if (settle_q == SettleLast) begin
               settle_d = 8'd0;
               state_d  = StSample;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         StSample: begin
            raw_d[{bank_q, 3'b000} +: 8] = ~data_s;
            if (bank_q == 2'd3) begin
               state_d = StCompare;
            end else begin
               bank_d  = bank_q + 2'd1;
               state_d = StDrive;
            end
         end
         StCompare: begin
            if (raw_q == prev_q) begin
               stab_d = (stab_q >= DebTarget) ? DebTarget : stab_q + 4'd1;
            end else begin
               stab_d = 4'd1;
            end
            prev_d = raw_q;
            // First debounced frame must load even when it matches the reset value.
            if (stab_d == DebTarget && (raw_q != dip_q || !valid_q)) begin
               dip_d    = raw_q;
               valid_d  = 1'b1;
               change_d = (raw_q != dip_q);
            end
            done_d   = 1'b1;
            bank_d   = 2'd0;
            settle_d = 8'd0;
            state_d  = scan_en ? StDrive : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bank_sel = 4'hF;
      if (state_q == StDrive || state_q == StSample) begin
         bank_sel = ~(4'b0001 << bank_q);
      end
   end

   assign dip_sw     = dip_q;
   assign dip_valid  = valid_q;
   assign dip_change = change_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_gpio_switch_scanner.sv
// Self-checking bench for gpio_switch_scanner: a switch-board model drives bank_data and a
// frame-history debounce model predicts dip_sw / dip_valid / dip_change.
module tb_gpio_switch_scanner;

   localparam int unsigned Settle      = 4;
   localparam int unsigned Deb         = 3;
   localparam int          FramePeriod = 4 * (Settle + 1) + 1;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        scan_en = 1'b0;
   logic [3:0]  bank_sel;
   logic [7:0]  bank_data;
   logic [31:0] dip_sw;
   logic        dip_valid;
   logic        dip_change;
   logic        frame_done;

   logic [31:0] sw = 32'd0;
   logic        ovr_en = 1'b0;
   logic [7:0]  ovr_val = 8'hFF;

   int vectors = 0;
   int miscompares = 0;
   int change_seen = 0;
   int change_exp = 0;

   logic [31:0] m_dip = 32'd0;
   logic        m_valid = 1'b0;
   logic        m_chg = 1'b0;
   logic [31:0] hist[$];

   gpio_switch_scanner #(
      .SETTLE_CYCLES (Settle),
      .DEBOUNCE_SCANS(Deb)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .scan_en   (scan_en),
      .bank_sel  (bank_sel),
      .bank_data (bank_data),
      .dip_sw    (dip_sw),
      .dip_valid (dip_valid),
      .dip_change(dip_change),
      .frame_done(frame_done)
   );

   always #5 clock = ~clock;

   // Closed switch pulls its line low on the selected bank; unselected bus idles high.
   always_comb begin
      bank_data = 8'hFF;
      case (bank_sel)
         4'b1110: bank_data = ~sw[7:0];
         4'b1101: bank_data = ~sw[15:8];
         4'b1011: bank_data = ~sw[23:16];
         4'b0111: bank_data = ~sw[31:24];
         default: bank_data = 8'hFF;
      endcase
      if (ovr_en && bank_sel == 4'b1110) bank_data = ovr_val;
   end

   always @(negedge clock) if (reset_n && dip_change) change_seen++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // dip_sw follows a word once the last Deb frames all saw it.
   function automatic void model_frame(input logic [31:0] word);
      int run;
      hist.push_back(word);
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] != word) break;
         run++;
      end
      m_chg = 1'b0;
      if (run >= Deb && (word != m_dip || !m_valid)) begin
         m_chg   = (word != m_dip);
         m_dip   = word;
         m_valid = 1'b1;
      end
      if (m_chg) change_exp++;
   endfunction

   function automatic void model_reset();
      m_dip   = 32'd0;
      m_valid = 1'b0;
      m_chg   = 1'b0;
      hist.delete();
   endfunction

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      scan_en = 1'b0;
      ovr_en  = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic wait_frame();
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!frame_done && n < 4 * FramePeriod);
      if (!frame_done) begin
         vectors++;
         miscompares++;
         $display("FAIL frame_timeout: no frame_done within %0d cycles", n);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      #1;
      vectors++;
      if ({bank_sel, dip_sw, dip_valid, dip_change, frame_done} !== {4'hF, 32'd0, 3'b000}) begin
         miscompares++;
         $display("FAIL reset_state: got sel=%h sw=%h v=%b c=%b fd=%b expected sel=f sw=0 0 0 0",
                  bank_sel, dip_sw, dip_valid, dip_change, frame_done);
      end
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_bank_sequence();
      logic [3:0] one;
      logic [3:0] exp_sel;
      logic       exp_fd;
      int         pos;
      one = 4'b0001;
      @(negedge clock);
      scan_en = 1'b1;
      for (int k = 0; k < 2 * FramePeriod; k++) begin
         @(posedge clock);
         #1;
         pos     = k % FramePeriod;
         exp_sel = (pos == FramePeriod - 1) ? 4'hF : ~(one << (pos / (Settle + 1)));
         exp_fd  = (k >= FramePeriod) && (pos == 0);
         vectors++;
         if ({bank_sel, frame_done} !== {exp_sel, exp_fd}) begin
            miscompares++;
            $display("FAIL bank_seq[%0d]: got sel=%b fd=%b expected sel=%b fd=%b",
                     k, bank_sel, frame_done, exp_sel, exp_fd);
         end
      end
      do_reset();
   endtask

   task automatic test_static();
      int c0;
      c0 = change_seen;
      sw = 32'hA5C3_0FF0;
      @(negedge clock);
      scan_en = 1'b1;
      for (int f = 1; f <= 5; f++) begin
         wait_frame();
         model_frame(sw);
         vectors++;
         if ({dip_sw, dip_valid, dip_change} !== {m_dip, m_valid, m_chg}) begin
            miscompares++;
            $display("FAIL static_frame%0d: got %h/%b/%b expected %h/%b/%b",
                     f, dip_sw, dip_valid, dip_change, m_dip, m_valid, m_chg);
         end
         vectors++;
         if (dip_valid !== (f >= 3)) begin
            miscompares++;
            $display("FAIL static_valid%0d: got %b expected %b", f, dip_valid, f >= 3);
         end
      end
      vectors++;
      if (dip_sw !== 32'hA5C3_0FF0) begin
         miscompares++;
         $display("FAIL static_word: got %h expected a5c30ff0", dip_sw);
      end
      vectors++;
      if (change_seen - c0 !== 1) begin
         miscompares++;
         $display("FAIL static_change_count: got %0d expected 1", change_seen - c0);
      end
   endtask

   task automatic test_bounce();
      logic [31:0] base;
      int          c0;
      base = sw;
      c0   = change_seen;
      for (int f = 0; f < 10; f++) begin
         sw = (f % 2 == 0) ? (base ^ 32'h100) : base;
         wait_frame();
         model_frame(sw);
         vectors++;
         if ({dip_sw, dip_valid, dip_change} !== {base, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL bounce_hold%0d: got %h/%b/%b expected %h/1/0",
                     f, dip_sw, dip_valid, dip_change, base);
         end
      end
      vectors++;
      if (change_seen !== c0) begin
         miscompares++;
         $display("FAIL bounce_no_change: got %0d pulses expected 0", change_seen - c0);
      end
      sw = base ^ 32'h100;
      for (int f = 1; f <= 3; f++) begin
         wait_frame();
         model_frame(sw);
         vectors++;
         if ({dip_sw, dip_valid, dip_change} !== {m_dip, m_valid, m_chg}) begin
            miscompares++;
            $display("FAIL bounce_settle%0d: got %h/%b/%b expected %h/%b/%b",
                     f, dip_sw, dip_valid, dip_change, m_dip, m_valid, m_chg);
         end
      end
      vectors++;
      if (dip_sw[8] !== ~base[8]) begin
         miscompares++;
         $display("FAIL bounce_bit8: got %b expected %b", dip_sw[8], ~base[8]);
      end
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      for (int f = 0; f < 40; f++) begin
         if (hold == 0) begin
            if ($urandom_range(0, 1) == 0) sw = $urandom;
            else sw = sw ^ (32'd1 << $urandom_range(0, 31));
            hold = $urandom_range(1, 5);
         end
         hold--;
         wait_frame();
         model_frame(sw);
         vectors++;
         if ({dip_sw, dip_valid, dip_change} !== {m_dip, m_valid, m_chg}) begin
            miscompares++;
            $display("FAIL random_frame%0d: got %h/%b/%b expected %h/%b/%b",
                     f, dip_sw, dip_valid, dip_change, m_dip, m_valid, m_chg);
         end
      end
      vectors++;
      if (change_seen !== change_exp) begin
         miscompares++;
         $display("FAIL change_total: got %0d pulses expected %0d", change_seen, change_exp);
      end
   endtask

   task automatic test_scan_stop();
      int   n;
      logic saw3;
      logic idle_ok;
      n = 0;
      while (bank_sel != 4'b1011 && n < 4 * FramePeriod) begin
         @(negedge clock);
         n++;
      end
      scan_en = 1'b0;
      saw3 = 1'b0;
      n = 0;
      do begin
         @(negedge clock);
         n++;
         if (bank_sel == 4'b0111) saw3 = 1'b1;
      end while (!frame_done && n < 4 * FramePeriod);
      vectors++;
      if ({saw3, frame_done} !== 2'b11) begin
         miscompares++;
         $display("FAIL stop_completes: got bank3=%b fd=%b expected 1 1", saw3, frame_done);
      end
      model_frame(sw);
      vectors++;
      if ({dip_sw, dip_valid, dip_change} !== {m_dip, m_valid, m_chg}) begin
         miscompares++;
         $display("FAIL stop_frame: got %h/%b/%b expected %h/%b/%b",
                  dip_sw, dip_valid, dip_change, m_dip, m_valid, m_chg);
      end
      idle_ok = 1'b1;
      for (int k = 0; k < 3 * FramePeriod; k++) begin
         @(negedge clock);
         if (bank_sel !== 4'hF || frame_done !== 1'b0) idle_ok = 1'b0;
      end
      vectors++;
      if (idle_ok !== 1'b1) begin
         miscompares++;
         $display("FAIL stop_idle: got activity after stop expected sel=f fd=0");
      end
   endtask

   task automatic test_reset_mid();
      int n;
      sw = $urandom | 32'h1;
      @(negedge clock);
      scan_en = 1'b1;
      n = 0;
      while (bank_sel != 4'b1110 && n < 4 * FramePeriod) begin
         @(negedge clock);
         n++;
      end
      while (bank_sel != 4'b1101 && n < 8 * FramePeriod) begin
         @(negedge clock);
         n++;
      end
      repeat (Settle) @(negedge clock);
      reset_n = 1'b0;
      #1;
      model_reset();
      vectors++;
      if ({bank_sel, dip_sw, dip_valid} !== {4'hF, 32'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_mid: got sel=%h sw=%h v=%b expected sel=f sw=0 v=0",
                  bank_sel, dip_sw, dip_valid);
      end
      @(negedge clock);
      reset_n = 1'b1;
      for (int f = 1; f <= Deb; f++) begin
         wait_frame();
         model_frame(sw);
         vectors++;
         if ({dip_sw, dip_valid, dip_change} !== {m_dip, m_valid, m_chg}) begin
            miscompares++;
            $display("FAIL reset_restart%0d: got %h/%b/%b expected %h/%b/%b",
                     f, dip_sw, dip_valid, dip_change, m_dip, m_valid, m_chg);
         end
         vectors++;
         if (dip_valid !== (f == Deb)) begin
            miscompares++;
            $display("FAIL reset_valid%0d: got %b expected %b", f, dip_valid, f == Deb);
         end
      end
   endtask

`ifdef GPIO_SW_SYNC_EN
   task automatic test_sync();
      logic [7:0]  newb;
      logic [31:0] exp_word;
      int          n;
      newb = 8'h5A;
      for (int lead = 1; lead <= 3; lead += 2) begin
         do_reset();
         sw = 32'h0000_0011;
         exp_word = (lead == 1) ? sw : {sw[31:8], newb};
         @(negedge clock);
         scan_en = 1'b1;
         for (int f = 0; f < Deb; f++) begin
            n = 0;
            while (bank_sel != 4'b1110 && n < 4 * FramePeriod) begin
               @(negedge clock);
               n++;
            end
            repeat (Settle - lead) @(negedge clock);
            ovr_val = ~newb;
            ovr_en  = 1'b1;
            wait_frame();
            ovr_en = 1'b0;
            model_frame(exp_word);
         end
         vectors++;
         if ({dip_sw, dip_valid} !== {m_dip, m_valid}) begin
            miscompares++;
            $display("FAIL sync_lead%0d: got %h/%b expected %h/%b",
                     lead, dip_sw, dip_valid, m_dip, m_valid);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_bank_sequence();
      test_static();
      test_bounce();
      test_random();
      test_scan_stop();
      test_reset_mid();
`ifdef GPIO_SW_SYNC_EN
      test_sync();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
